fc_controller: RTL and testbench

- Sequencer for the fully-connected MAC datapath (fc layer): for each output neuron, clears the accumulator and streams input chunks of OPS_PER_CYCLE lanes.
- Drives activation-buffer and weight-ROM read addresses and aligns the datapath valid and lane-mask to the one-cycle memory latency.
- Captures each finished dot product and presents it on a valid/ready output stream.
- Sits between the layer scheduler (start/done) and the fc datapath plus its memories.

---
 rtl/fc_pkg.sv | 27 ++
 rtl/fc_addr_gen.sv | 48 ++++
 rtl/fc_controller.sv | 159 +++++++++++++++
 tb/tb_fc_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and sizing helpers for the fully-connected layer controller.
package fc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FETCH,
        DRAIN,
        EMIT,
        DONE
    } fc_ctrl_state;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

    // Lanes used by the final (possibly partial) chunk of a neuron.
    function automatic int last_lanes(input int in_count, input int ops);
        return in_count - (ceil_div(in_count, ops) - 1) * ops;
    endfunction

    localparam int DEF_IN_COUNT      = 1024;
    localparam int DEF_OPS_PER_CYCLE = 10;
    localparam int DEF_CHUNKS        = ceil_div(DEF_IN_COUNT, DEF_OPS_PER_CYCLE);
    localparam int DEF_LAST_LANES    = last_lanes(DEF_IN_COUNT, DEF_OPS_PER_CYCLE);

endpackage

// File: rtl/fc_addr_gen.sv
// Chunk counter, running weight-row base and per-chunk lane mask for the fc sequencer.
module fc_addr_gen
    import fc_pkg::*;
#(
    parameter int OPS_PER_CYCLE = 10,
    parameter int IN_COUNT      = 1024,
    parameter int CHUNK_W       = 7,
    parameter int WGT_W         = 17
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     layer_start,
    input  logic                     chunk_clear,
    input  logic                     chunk_step,
    input  logic                     base_step,
    output logic [CHUNK_W-1:0]       chunk,
    output logic [WGT_W-1:0]         base,
    output logic                     last_chunk,
    output logic [OPS_PER_CYCLE-1:0] lane_mask
);

    localparam int CHUNKS     = ceil_div(IN_COUNT, OPS_PER_CYCLE);
    localparam int LAST_LANES = last_lanes(IN_COUNT, OPS_PER_CYCLE);
    localparam logic [OPS_PER_CYCLE-1:0] FULL_MASK = '1;
    localparam logic [OPS_PER_CYCLE-1:0] LAST_MASK = FULL_MASK >> (OPS_PER_CYCLE - LAST_LANES);

    // Base advances by CHUNKS per neuron so no multiplier is needed for the weight row.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chunk <= '0;
            base  <= '0;
        end else begin
            if (layer_start)
                base <= '0;
            else if (base_step)
                base <= base + WGT_W'(CHUNKS);

            if (chunk_clear)
                chunk <= '0;
            else if (chunk_step && !last_chunk)
                chunk <= chunk + CHUNK_W'(1);
        end
    end

    assign last_chunk = (chunk == CHUNK_W'(CHUNKS - 1));
    assign lane_mask  = last_chunk ? LAST_MASK : FULL_MASK;

endmodule

// File: rtl/fc_controller.sv
// Sequencer for the fc MAC datapath: per neuron clear, stream chunks, drain, emit result.
module fc_controller
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int OPS_PER_CYCLE = 10,
    parameter int IN_COUNT      = 1024,
    parameter int OUT_COUNT     = 1000,
    parameter int ACC_WIDTH     = 32,
    parameter int ACC_LATENCY   = 1,
    localparam int CHUNKS  = ceil_div(IN_COUNT, OPS_PER_CYCLE),
    localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
    localparam int WGT_W   = (OUT_COUNT * CHUNKS > 1) ? $clog2(OUT_COUNT * CHUNKS) : 1,
    localparam int IDX_W   = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     act_rd_en,
    output logic [CHUNK_W-1:0]       act_rd_addr,
    output logic                     wgt_rd_en,
    output logic [WGT_W-1:0]         wgt_rd_addr,
    output logic                     fc_clear,
    output logic                     fc_valid,
    output logic [OPS_PER_CYCLE-1:0] fc_lane_mask,
    input  logic [ACC_WIDTH-1:0]     fc_acc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ACC_WIDTH-1:0]     out_data,
    output logic [IDX_W-1:0]         out_index
);

    localparam int DRAIN_W = (ACC_LATENCY > 0) ? $clog2(ACC_LATENCY + 1) : 1;

    if (ACC_WIDTH < DATA_WIDTH) begin : g_bad_width
        $error("fc_controller: ACC_WIDTH narrower than DATA_WIDTH");
    end

    fc_ctrl_state state, state_nxt;

    logic [IDX_W-1:0]         neuron;
    logic [DRAIN_W-1:0]       drain_cnt;
    logic [CHUNK_W-1:0]       chunk;
    logic [WGT_W-1:0]         base;
    logic                     last_chunk;
    logic [OPS_PER_CYCLE-1:0] mask_p0;
    logic                     vld_p1;
    logic [OPS_PER_CYCLE-1:0] mask_p1;
    logic                     layer_start;
    logic                     handshake;
    logic                     last_neuron;
    logic                     drain_last;

    assign layer_start = (state == IDLE) && start;
    assign handshake   = (state == EMIT) && out_ready;
    assign last_neuron = (neuron == IDX_W'(OUT_COUNT - 1));
    assign drain_last  = (drain_cnt == DRAIN_W'(ACC_LATENCY));

    fc_addr_gen #(
        .OPS_PER_CYCLE (OPS_PER_CYCLE),
        .IN_COUNT      (IN_COUNT),
        .CHUNK_W       (CHUNK_W),
        .WGT_W         (WGT_W)
    ) u_addr_gen (
        .clock       (clock),
        .reset       (reset),
        .layer_start (layer_start),
        .chunk_clear (state == CLEAR),
        .chunk_step  (state == FETCH),
        .base_step   (handshake && !last_neuron),
        .chunk       (chunk),
        .base        (base),
        .last_chunk  (last_chunk),
        .lane_mask   (mask_p0)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = FETCH;
            FETCH:   if (last_chunk) state_nxt = DRAIN;
            DRAIN:   if (drain_last) state_nxt = EMIT;
            EMIT:    if (out_ready) state_nxt = last_neuron ? DONE : CLEAR;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        fc_clear  = 1'b0;
        act_rd_en = 1'b0;
        out_valid = 1'b0;
        case (state)
            CLEAR: begin
                busy     = 1'b1;
                fc_clear = 1'b1;
            end
            FETCH: begin
                busy      = 1'b1;
                act_rd_en = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign wgt_rd_en   = act_rd_en;
    assign act_rd_addr = act_rd_en ? chunk : '0;
    assign wgt_rd_addr = act_rd_en ? base + WGT_W'(chunk) : '0;

    // p0 -> p1: memory read latency; valid and mask return with the data
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            mask_p1   <= '0;
            neuron    <= '0;
            drain_cnt <= '0;
            out_data  <= '0;
            out_index <= '0;
        end else begin
            vld_p1  <= act_rd_en;
            mask_p1 <= act_rd_en ? mask_p0 : '0;

            if (layer_start)
                neuron <= '0;
            else if (handshake && !last_neuron)
                neuron <= neuron + IDX_W'(1);

            if (state == DRAIN)
                drain_cnt <= drain_last ? '0 : drain_cnt + DRAIN_W'(1);

            if ((state == DRAIN) && drain_last) begin
                out_data  <= fc_acc;
                out_index <= neuron;
            end
        end
    end

    assign fc_valid     = vld_p1;
    assign fc_lane_mask = mask_p1;

endmodule

// File: tb/tb_fc_controller.sv
// Directed bench for fc_controller: partial-chunk config (A) and exact-fit, 3-cycle accumulator config (B).
module tb_fc_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Config A: IN_COUNT=25, OPS=10, OUT_COUNT=3, ACC_LATENCY=1 -> CHUNKS=3, last mask 0x01F
    logic        start_a = 1'b0, out_ready_a = 1'b1;
    logic        busy_a, done_a, act_rd_en_a, wgt_rd_en_a, fc_clear_a, fc_valid_a, out_valid_a;
    logic [1:0]  act_rd_addr_a, out_index_a;
    logic [3:0]  wgt_rd_addr_a;
    logic [9:0]  mask_a;
    logic [31:0] fc_acc_a, out_data_a;

    fc_controller #(.DATA_WIDTH(8), .OPS_PER_CYCLE(10), .IN_COUNT(25), .OUT_COUNT(3),
                    .ACC_WIDTH(32), .ACC_LATENCY(1)) dut_a (
        .clock(clock), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a),
        .act_rd_en(act_rd_en_a), .act_rd_addr(act_rd_addr_a), .wgt_rd_en(wgt_rd_en_a),
        .wgt_rd_addr(wgt_rd_addr_a), .fc_clear(fc_clear_a), .fc_valid(fc_valid_a),
        .fc_lane_mask(mask_a), .fc_acc(fc_acc_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .out_data(out_data_a), .out_index(out_index_a));

    // Config B: IN_COUNT=20, OPS=10, OUT_COUNT=2, ACC_LATENCY=3 -> CHUNKS=2, last mask 0x3FF
    logic        start_b = 1'b0, out_ready_b = 1'b1;
    logic        busy_b, done_b, act_rd_en_b, wgt_rd_en_b, fc_clear_b, fc_valid_b, out_valid_b;
    logic [0:0]  act_rd_addr_b, out_index_b;
    logic [1:0]  wgt_rd_addr_b;
    logic [9:0]  mask_b;
    logic [31:0] fc_acc_b, out_data_b;

    fc_controller #(.DATA_WIDTH(8), .OPS_PER_CYCLE(10), .IN_COUNT(20), .OUT_COUNT(2),
                    .ACC_WIDTH(32), .ACC_LATENCY(3)) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b),
        .act_rd_en(act_rd_en_b), .act_rd_addr(act_rd_addr_b), .wgt_rd_en(wgt_rd_en_b),
        .wgt_rd_addr(wgt_rd_addr_b), .fc_clear(fc_clear_b), .fc_valid(fc_valid_b),
        .fc_lane_mask(mask_b), .fc_acc(fc_acc_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .out_data(out_data_b), .out_index(out_index_b));

    // Datapath model: each returned lane adds its global input index; each chunk adds its weight address.
    function automatic int lane_sum(input int addr, input logic [9:0] mask);
        int s = 0;
        for (int l = 0; l < 10; l++)
            if (mask[l]) s += addr * 10 + l;
        return s;
    endfunction

    logic [1:0]  addr_a_d;
    logic [3:0]  wgt_a_d;
    logic [31:0] acc_a;
    always @(posedge clock) begin
        addr_a_d <= act_rd_addr_a;
        wgt_a_d  <= wgt_rd_addr_a;
        if (fc_clear_a)      acc_a <= 32'd0;
        else if (fc_valid_a) acc_a <= acc_a + 32'(lane_sum(int'(addr_a_d), mask_a)) + 32'(wgt_a_d);
    end
    assign fc_acc_a = acc_a;

    logic [0:0]  addr_b_d;
    logic [1:0]  wgt_b_d;
    logic [31:0] acc_b, acc_b_d1, acc_b_d2;
    always @(posedge clock) begin
        addr_b_d <= act_rd_addr_b;
        wgt_b_d  <= wgt_rd_addr_b;
        if (fc_clear_b)      acc_b <= 32'd0;
        else if (fc_valid_b) acc_b <= acc_b + 32'(lane_sum(int'(addr_b_d), mask_b)) + 32'(wgt_b_d);
        acc_b_d1 <= acc_b;
        acc_b_d2 <= acc_b_d1;
    end
    assign fc_acc_b = acc_b_d2;

    int hs_a_cnt = 0, done_a_cnt = 0;
    always @(posedge clock) begin
        if (out_valid_a && out_ready_a) hs_a_cnt <= hs_a_cnt + 1;
        if (done_a)                     done_a_cnt <= done_a_cnt + 1;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_busy"},  busy_a, 0);
        chk({tag, "_done"},  done_a, 0);
        chk({tag, "_rd_en"}, act_rd_en_a, 0);
        chk({tag, "_wgt_en"}, wgt_rd_en_a, 0);
        chk({tag, "_aaddr"}, act_rd_addr_a, 0);
        chk({tag, "_waddr"}, wgt_rd_addr_a, 0);
        chk({tag, "_clear"}, fc_clear_a, 0);
        chk({tag, "_vld"},   fc_valid_a, 0);
        chk({tag, "_mask"},  mask_a, 0);
        chk({tag, "_ovld"},  out_valid_a, 0);
        chk({tag, "_odata"}, out_data_a, 0);
        chk({tag, "_oidx"},  out_index_a, 0);
    endtask

    // Entered at the CLEAR cycle of neuron n; returns one cycle after the EMIT handshake.
    task automatic neuron_a(input int n, input int exp_data, input int stall);
        chk("a_clear", fc_clear_a, 1);
        chk("a_busy", busy_a, 1);
        chk("a_clear_novld", fc_valid_a, 0);
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("a_rd_en", act_rd_en_a, 1);
            chk("a_wgt_en", wgt_rd_en_a, 1);
            chk("a_act_addr", act_rd_addr_a, c);
            chk("a_wgt_addr", wgt_rd_addr_a, 3 * n + c);
            chk("a_fetch_vld", fc_valid_a, (c > 0) ? 1 : 0);
            if (c > 0) chk("a_mask_full", mask_a, 10'h3FF);
        end
        tick;
        chk("a_drain_rd_en", act_rd_en_a, 0);
        chk("a_last_vld", fc_valid_a, 1);
        chk("a_mask_last", mask_a, 10'h01F);
        tick;
        chk("a_drain1_vld", fc_valid_a, 0);
        chk("a_drain1_ovld", out_valid_a, 0);
        out_ready_a = (stall == 0);
        tick;
        chk("a_emit_ovld", out_valid_a, 1);
        chk("a_emit_data", out_data_a, exp_data);
        chk("a_emit_idx", out_index_a, n);
        for (int s = 0; s < stall; s++) begin
            tick;
            chk("a_stall_ovld", out_valid_a, 1);
            chk("a_stall_data", out_data_a, exp_data);
            chk("a_stall_idx", out_index_a, n);
            chk("a_stall_noclr", fc_clear_a, 0);
        end
        out_ready_a = 1'b1;
        tick;
        chk("a_ovld_drop", out_valid_a, 0);
    endtask

    initial begin
        int waited;

        // Reset state
        tick;
        tick;
        chk_idle_a("rst");
        chk("rst_b_busy", busy_b, 0);
        reset = 1'b0;

        // Run 1: start held high through neuron 0 (ignored while busy), backpressure on neuron 1
        start_a = 1'b1;
        tick;
        neuron_a(0, 303, 0);
        start_a = 1'b0;
        neuron_a(1, 312, 5);
        neuron_a(2, 321, 0);
        chk("a_done", done_a, 1);
        chk("a_done_busy", busy_a, 0);
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        chk("a_done_drop", done_a, 0);
        chk("a_start_in_done_ignored", fc_clear_a, 0);
        tick;
        chk("a_idle_busy", busy_a, 0);
        chk("a_idle_clear", fc_clear_a, 0);
        chk("a_result_count", hs_a_cnt, 3);
        chk("a_done_count", done_a_cnt, 1);

        // Run 2: asynchronous reset in the middle of neuron 1's fetch
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        neuron_a(0, 303, 0);
        tick;
        tick;
        chk("a_pre_rst_vld", fc_valid_a, 1);
        #2 reset = 1'b1;
        #1 chk_idle_a("midrst");
        tick;
        reset = 1'b0;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        neuron_a(0, 303, 0);
        neuron_a(1, 312, 0);
        neuron_a(2, 321, 0);
        chk("a_done_2", done_a, 1);

        // Config B: exact-fit last chunk and four DRAIN cycles before capture
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        chk("b_clear", fc_clear_b, 1);
        tick;
        chk("b_addr0", act_rd_addr_b, 0);
        chk("b_wgt0", wgt_rd_addr_b, 0);
        tick;
        chk("b_addr1", act_rd_addr_b, 1);
        chk("b_wgt1", wgt_rd_addr_b, 1);
        chk("b_mask0", mask_b, 10'h3FF);
        tick;
        chk("b_drain_rd_en", act_rd_en_b, 0);
        chk("b_last_vld", fc_valid_b, 1);
        chk("b_mask_last_full", mask_b, 10'h3FF);
        tick;
        tick;
        tick;
        chk("b_drain3_ovld", out_valid_b, 0);
        chk("b_drain3_busy", busy_b, 1);
        tick;
        chk("b_emit0_ovld", out_valid_b, 1);
        chk("b_emit0_data", out_data_b, 191);
        chk("b_emit0_idx", out_index_b, 0);
        waited = 0;
        for (int k = 0; k < 20; k++) begin
            tick;
            waited++;
            if (out_valid_b) break;
        end
        chk("b_emit1_seen", out_valid_b, 1);
        chk("b_neuron_period", waited, 8);
        chk("b_emit1_data", out_data_b, 195);
        chk("b_emit1_idx", out_index_b, 1);
        tick;
        chk("b_done", done_b, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
